// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: folded FIR sharing one signed multiplier and one accumulator across all taps
module fir_mac_sequencer #(
    parameter int TAPS = 100,
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int OW   = 32,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] din,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [OW-1:0] dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_wdata,
    output logic                 coef_ready,
    input  logic                 flush,
    output logic                 busy
);
    localparam int TW = $clog2(TAPS);
    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;
    state_t state, state_nx;
    logic [TW-1:0] tap, wr_ptr, rd_ptr;
    logic signed [DW-1:0] hist [TAPS];
    logic signed [CW-1:0] coef [TAPS];
    logic signed [OW-1:0] acc, sum;
    logic signed [DW+CW-1:0] prod;
    logic idle, accept, last, coef_hit;
    assign idle       = state == IDLE;
    assign in_ready   = idle && !coef_we && !flush;
    assign coef_ready = idle;
    assign busy       = !idle;
    assign accept     = in_ready && in_valid;
    assign last       = tap == TW'(TAPS - 1);
    assign coef_hit   = int'(coef_addr) < TAPS;
    assign prod       = (DW+CW)'(hist[rd_ptr]) * (DW+CW)'(coef[tap]);
    assign sum        = acc + OW'(prod);
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // next state: accept starts a run, the last tap ends it, the consumer releases the output
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE && accept)          ? RUN  :
                   (state == RUN  && last)            ? OUT  :
                   (state == OUT  && out_ready)       ? IDLE : state;
    end
    // datapath: history/coefficient storage, one MAC per RUN cycle, output register
    always_ff @(posedge clk) begin
        if (rst) begin
            tap       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            acc       <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
                coef[i] <= '0;
            end
        end else begin
            if (idle && flush) begin
                for (int i = 0; i < TAPS; i++) hist[i] <= '0;
            end else if (idle && coef_we) begin
                if (coef_hit) coef[coef_addr[TW-1:0]] <= coef_wdata;
            end else if (accept) begin
                hist[wr_ptr] <= din;
                rd_ptr       <= wr_ptr;
                wr_ptr       <= (wr_ptr == TW'(TAPS - 1)) ? '0 : wr_ptr + TW'(1);
                acc          <= '0;
                tap          <= '0;
            end
            if (state == RUN) begin
                acc    <= sum;
                tap    <= last ? '0 : tap + TW'(1);
                rd_ptr <= (rd_ptr == '0) ? TW'(TAPS - 1) : rd_ptr - TW'(1);
                if (last) begin
                    dout      <= sum;
                    out_valid <= 1'b1;
                end
            end
            if (state == OUT && out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: scoreboard bench for a 4-tap folded FIR
module tb_fir_mac_sequencer;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, coef_we, coef_ready, flush, busy;
    logic signed [15:0] din, coef_wdata;
    logic signed [31:0] dout;
    logic [2:0] coef_addr;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    always #5 clk = ~clk;
    fir_mac_sequencer #(.TAPS(4), .DW(16), .CW(16), .OW(32), .AW(3)) dut (
        .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready),
        .dout(dout), .out_valid(out_valid), .out_ready(out_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_ready(coef_ready), .flush(flush), .busy(busy)
    );
    // monitor: every output the consumer takes must match the oldest expected value
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got %0d want none", dout);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    errors++;
                    $display("FAIL dout got %0d want %0d", dout, $signed(e));
                end
            end
        end
    end
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, $signed(got), $signed(want));
        end
    endtask
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got busy=1 want busy=0");
        end
    endtask
    task automatic send(input logic signed [15:0] s, input logic [31:0] e, input bit push);
        wait_idle();
        din = s;
        in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask
    task automatic wcoef(input logic [2:0] a, input logic signed [15:0] d);
        wait_idle();
        coef_we = 1'b1;
        coef_addr = a;
        coef_wdata = d;
        #1;
        chk("coef_ready_idle", 32'(coef_ready), 32'd1);
        chk("in_ready_during_we", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask
    task automatic do_flush();
        wait_idle();
        flush = 1'b1;
        #1;
        chk("in_ready_during_flush", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask
    initial begin
        int first_v, first_r, n;
        rst = 1'b1; din = '0; in_valid = 1'b0; out_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_dout", dout, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_coef_ready", 32'(coef_ready), 32'd1);
        // impulse response
        wcoef(0, 3); wcoef(1, -5); wcoef(2, 7); wcoef(3, -2);
        send(1, 3, 1); send(0, -5, 1); send(0, 7, 1); send(0, -2, 1); send(0, 0, 1);
        // writes while busy and out-of-range writes are ignored
        send(1, 3, 1);
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'sd100;
        #1;
        chk("coef_ready_run", 32'(coef_ready), 32'd0);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        send(0, -5, 1); send(0, 7, 1); send(0, -2, 1);
        wcoef(3'd4, 55); wcoef(3'd7, 55);
        send(1, 3, 1); send(0, -5, 1); send(0, 7, 1); send(0, -2, 1);
        // latency and handshake timing from the accepting edge
        wait_idle();
        din = 2; in_valid = 1'b1; exp_q.push_back(32'd6);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        first_v = -1; first_r = -1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (out_valid && first_v < 0) first_v = c;
            if (in_ready && first_r < 0) first_r = c;
        end
        chk("latency_out_valid", 32'(first_v), 32'd4);
        chk("latency_in_ready", 32'(first_r), 32'd5);
        // backpressure with ignored inputs while holding the output
        out_ready = 1'b0;
        send(1, -7, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_reach_out", 32'(out_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; din = 9; flush = 1'b1;
            coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'sd100;
            #1;
            chk("bp_hold", {dout[28:0], out_valid, in_ready, coef_ready},
                {29'h1FFFFFF9, 1'b1, 1'b0, 1'b0});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; flush = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_dout", dout, -32'sd7);
        // flush clears history
        wcoef(0, 1); wcoef(1, 1); wcoef(2, 1); wcoef(3, 1);
        send(5, 8, 1); send(5, 13, 1); send(5, 16, 1);
        do_flush();
        send(1, 1, 1);
        // reset in the middle of a run aborts it and clears coefficients
        send(1, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_dout", dout, 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        send(1, 0, 1); send(0, 0, 1);
        // accumulator wraps modulo 2^32
        do_flush();
        wcoef(0, -32768); wcoef(1, -32768); wcoef(2, -32768); wcoef(3, -32768);
        send(-32768, 32'h4000_0000, 1);
        send(-32768, 32'h8000_0000, 1);
        send(-32768, 32'hC000_0000, 1);
        send(-32768, 32'h0000_0000, 1);
        wait_idle();
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Folded FIR controller that time-shares one signed multiplier and one accumulator across all taps of a TAPS-tap filter.
- Holds the sample history in a circular buffer and the coefficients in a writable register file.
- Sequences one multiply-accumulate per clock and returns one filtered output per accepted sample.
- Serves low-rate channels where a fully parallel pipelined FIR costs too much area.
- The host loads coefficients through a configuration port while the block is idle.

Parameters:
TAPS, 100, number of filter taps (>=2)
DW, 16, signed input sample width
CW, 16, signed coefficient width
OW, 32, signed accumulator/output width
AW, $clog2(TAPS), coefficient address width (derived)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
din  input  DW  signed input sample
in_valid  input  1  din valid
in_ready  output  1  block can accept a sample this cycle
dout  output  OW  signed filtered output
out_valid  output  1  dout valid
out_ready  input  1  consumer accepts dout
coef_we  input  1  coefficient write strobe
coef_addr  input  AW  tap index written
coef_wdata  input  CW  signed coefficient value
coef_ready  output  1  coefficient write accepted this cycle
flush  input  1  clear sample history
busy  output  1  state != IDLE

Behaviour:
- One clock domain; reset is synchronous and active-high. While rst=1 at a clock edge:
  - state<=IDLE, tap counter<=0, wr_ptr<=0, acc<=0.
  - All history and coefficient entries <=0.
  - dout<=0, out_valid<=0.
- rst mid-RUN or mid-OUT aborts the operation. No output is produced for the aborted sample.
- States:
  - IDLE: in_ready=1 unless coef_we=1 or flush=1. coef_ready=1. busy=0.
  - RUN: in_ready=0, coef_ready=0, busy=1.
  - OUT: out_valid=1, in_ready=0, coef_ready=0, busy=1.
- IDLE, priority flush > coef_we > in_valid:
  - flush: all history entries <=0; wr_ptr unchanged.
  - coef_we: coef[coef_addr]<=coef_wdata. An address >= TAPS is ignored with no side effect.
  - in_valid&&in_ready: hist[wr_ptr]<=din, acc<=0, tap<=0, state<=RUN.
- wr_ptr handling: wr_ptr marks the newest sample. It advances after the write (TAPS-1 wraps to 0) on the same edge as the RUN entry. The term for tap k therefore reads x[n-k] = hist[(newest - k) mod TAPS].
- RUN, each edge:
  - acc <= acc + sext(x[n-tap]*coef[tap]). Full DW+CW-bit signed product, sign-extended to OW.
  - tap <= tap+1.
  - On the edge where tap==TAPS-1, also state<=OUT and dout<=final sum. Exactly TAPS RUN cycles.
- Arithmetic: two's complement; acc wraps modulo 2^OW with no saturation.
- OUT: dout and out_valid are held stable until out_ready=1. On that edge out_valid<=0 and state<=IDLE. dout keeps its last value.
- Latency: the accepting edge is E0. out_valid rises after edge E0+TAPS, so it is high in the cycle after that edge. With out_ready held high, throughput is one sample per TAPS+2 cycles.
- Inputs ignored while not in IDLE: coef_we, flush and in_valid have no effect. The coef_ready and in_ready deassertions signal this.
- Coefficients and history persist across samples and are cleared only by rst (history also by flush).

Test Plan:
1. TAPS=4. Load coef {3,-5,7,-2}, then drive samples 1,0,0,0,0 -> dout sequence 3,-5,7,-2,0.
2. Latency/handshake: accept a sample at edge E0 with out_ready=1 -> out_valid first high after edge E0+4 (TAPS=4), in_ready low from E0 until return to IDLE, next accept no earlier than E0+6.
3. Backpressure: hold out_ready=0 for 10 cycles in OUT -> dout and out_valid stable; in_ready=0 and coef_ready=0 throughout; release -> out_valid drops next edge.
4. Busy writes: pulse coef_we (addr 0, data 100) during RUN and addr=TAPS during IDLE -> coef unchanged; an impulse still yields the original coefficients.
5. Wrap: TAPS=4, all coef=-32768, four samples of -32768 -> the fourth output is 4*2^30 mod 2^32 = 0. The first three outputs are 2^30, -2^31 (wrapped) and -2^30.
6. Reset/flush: assert rst mid-RUN -> out_valid=0, dout=0, in_ready=1 next cycle, and an impulse then gives all zeros until coefs reload. Separately, flush after history 5,5,5 -> the next sample 1 with coef {1,1,1,1} gives 1.
